// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and bus widths for the memory arbiter
package mem_arbiter_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    // Owner of the bus is implied by the state: WAIT_x/RESP_x belong to x, LOCK to data
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_WAIT_IF = 3'd1,
        ARB_WAIT_DM = 3'd2,
        ARB_RESP_IF = 3'd3,
        ARB_RESP_DM = 3'd4,
        ARB_LOCK    = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-bus arbiter between instruction fetch and data port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       if_req_i,
    input  logic [INST_ADDR_BUS_W-1:0] if_addr_i,
    output logic                       if_rvalid_o,
    output logic [REG_BUS_W-1:0]       if_rdata_o,
    input  logic                       dm_req_i,
    input  logic                       dm_we_i,
    input  logic [3:0]                 dm_be_i,
    input  logic [REG_BUS_W-1:0]       dm_addr_i,
    input  logic [REG_BUS_W-1:0]       dm_wdata_i,
    input  logic                       dm_lock_i,
    output logic                       dm_rvalid_o,
    output logic [REG_BUS_W-1:0]       dm_rdata_o,
    output logic                       bus_req_o,
    output logic                       bus_we_o,
    output logic [3:0]                 bus_be_o,
    output logic [REG_BUS_W-1:0]       bus_addr_o,
    output logic [REG_BUS_W-1:0]       bus_wdata_o,
    input  logic                       bus_gnt_i,
    input  logic                       bus_rvalid_i,
    input  logic [REG_BUS_W-1:0]       bus_rdata_i,
    output logic                       stall_if_o,
    output logic                       stall_mem_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_t    r_state;
    logic [CW-1:0] r_starve_cnt;

    logic          w_starved;
    logic          w_if_win;
    logic          w_dm_win;
    arb_owner_t    w_cmd_owner;

    // Arbitration in IDLE and selection of which requester drives the command
    always_comb begin
        w_starved   = (r_starve_cnt == CW'(STARVE_MAX));
        w_if_win    = (r_state == ARB_IDLE) && if_req_i && (!dm_req_i || w_starved);
        w_dm_win    = (r_state == ARB_IDLE) && dm_req_i && !w_if_win;
        w_cmd_owner = OWN_NONE;
        case (r_state)
            ARB_IDLE: begin
                if (w_if_win)      w_cmd_owner = OWN_IF;
                else if (w_dm_win) w_cmd_owner = OWN_DM;
            end
            ARB_WAIT_IF: w_cmd_owner = OWN_IF;
            ARB_WAIT_DM: w_cmd_owner = OWN_DM;
            ARB_LOCK:    if (dm_req_i) w_cmd_owner = OWN_DM;
            default:     w_cmd_owner = OWN_NONE;
        endcase
        // Reset is asynchronous, so the command must also vanish combinationally
        if (!rst_i) w_cmd_owner = OWN_NONE;
    end

    // Command mux toward the bus; fields are zero unless a command is driven
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_be_o    = 4'h0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        case (w_cmd_owner)
            OWN_IF: begin
                bus_req_o  = 1'b1;
                bus_addr_o = if_addr_i;
            end
            OWN_DM: begin
                bus_req_o   = 1'b1;
                bus_we_o    = dm_we_i;
                bus_be_o    = dm_be_i;
                bus_addr_o  = dm_addr_i;
                bus_wdata_o = dm_wdata_i;
            end
            default: ;
        endcase
    end

    // Response demux; only the owner in RESP sees the bus response, stale responses are dropped
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        if (rst_i && r_state == ARB_RESP_IF) begin
            if_rvalid_o = bus_rvalid_i;
            if_rdata_o  = bus_rdata_i;
        end
        if (rst_i && r_state == ARB_RESP_DM) begin
            dm_rvalid_o = bus_rvalid_i;
            dm_rdata_o  = bus_rdata_i;
        end
        stall_if_o  = if_req_i && !if_rvalid_o;
        stall_mem_o = dm_req_i && !dm_rvalid_o;
    end

    // Arbiter FSM and fetch starvation counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ARB_IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_if_win) begin
                        r_starve_cnt <= '0;
                        r_state      <= bus_gnt_i ? ARB_RESP_IF : ARB_WAIT_IF;
                    end else if (w_dm_win) begin
                        if (if_req_i && !w_starved) r_starve_cnt <= r_starve_cnt + CW'(1);
                        r_state <= bus_gnt_i ? ARB_RESP_DM : ARB_WAIT_DM;
                    end
                end
                ARB_WAIT_IF: if (bus_gnt_i) r_state <= ARB_RESP_IF;
                ARB_WAIT_DM: if (bus_gnt_i) r_state <= ARB_RESP_DM;
                ARB_RESP_IF: if (bus_rvalid_i) r_state <= ARB_IDLE;
                ARB_RESP_DM: if (bus_rvalid_i) r_state <= dm_lock_i ? ARB_LOCK : ARB_IDLE;
                ARB_LOCK: begin
                    // Fetch is shut out until the data side releases the lock with no request pending
                    if (dm_req_i) begin
                        if (bus_gnt_i) r_state <= ARB_RESP_DM;
                    end else if (!dm_lock_i) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
